alu_ctrl_muldiv: RTL and testbench
==================================

Name: alu_ctrl_muldiv

Overview:
Second-generation ALU control for the pipelined MIPS EX stage. It keeps the combinational ALUCon decode from ALUOp/funct and adds NOR and illegal-op flagging. It also owns the HI/LO register pair and a multi-cycle iterative sequencer for mult/multu/div/divu, stalling the pipeline while it runs. mfhi and mflo are served from HI/LO through a dedicated read port.

Parameters:
WIDTH, 32, datapath width of operands, HI and LO.
ALUCON_W, 4, width of the ALUCon control word.

Ports:
clk  input  1  pipeline clock, rising edge.
reset  input  1  synchronous, active-high.
valid  input  1  EX-stage instruction valid (low for bubbles).
ALUOp  input  2  00 lw/sw, 01 beq, 10 R-type, 11 reserved.
funct  input  6  R-type function field.
rs_val  input  WIDTH  forwarded rs operand.
rt_val  input  WIDTH  forwarded rt operand.
ALUCon  output  ALUCON_W  ALU operation select, combinational.
illegal_op  output  1  combinational; high for valid instruction with unsupported decode.
stall  output  1  freeze PC, IF/ID and ID/EX; insert bubble into EX/MEM.
busy  output  1  sequencer not in IDLE.
hilo_out  output  WIDTH  HI for mfhi, LO for mflo, else 0.
div_by_zero  output  1  sticky; set by div/divu with rt_val==0, cleared by next mult/div issue or reset.

Behaviour:
- ALUCon decode is combinational:
  - ALUOp 00 -> 0010; ALUOp 01 -> 0110.
  - ALUOp 10 with funct 100100 -> 0000 (and), 100101 -> 0001 (or), 100000 -> 0010 (add), 100010 -> 0110 (sub), 101010 -> 0111 (slt), 100111 -> 1100 (nor).
  - ALUOp 10 with funct 011000/011001/011010/011011/010000/010010 (mult/multu/div/divu/mfhi/mflo) -> 0010. The ALU result is unused for these.
  - Any other funct, or ALUOp 11 -> 1111, and illegal_op=valid. No latch: every path assigns ALUCon.
- start = valid & ALUOp==10 & funct in {mult, multu, div, divu} & state==IDLE.
- FSM states and transitions:
  - IDLE: on start, latch |rs|,|rt| (signed ops) or raw values (unsigned), the result-sign flags and op type. Clear iteration count. Go to ITER.
  - ITER: one radix-2 step per cycle. Multiply uses shift-add into a 2*WIDTH accumulator. Divide uses restoring shift-subtract. After WIDTH steps (count==WIDTH-1), go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE.
    - mult: {HI,LO} = product, negated if operand signs differ.
    - div: LO = quotient, negated if signs differ; HI = remainder, carrying the sign of the dividend.
- stall = start | state==ITER | state==FIX. For an issue in cycle T, stall is high in cycles T..T+WIDTH+1 (WIDTH+2 cycles). HI/LO hold new values from cycle T+WIDTH+2.
- The held instruction stays in EX while stall is high. It is not re-issued because start requires IDLE, and the FSM is in FIX, not IDLE, in the last stall cycle.
- Divide by zero (rt_val==0 at issue): set div_by_zero and run the full WIDTH+2 cycles. Result is HI=rs_val, LO=all ones, with no sign correction.
- Signed overflow: div of MIN by -1 gives LO=MIN, HI=0. mult of MIN by MIN gives the correct 2*WIDTH result.
- mfhi/mflo (valid, ALUOp 10) drive hilo_out from the current HI/LO. They cannot coincide with FIX because the pipeline is stalled.
- A valid mult/div arriving while busy is impossible under a correct pipeline. The block ignores it with no restart and no corruption.
- Reset: synchronous; takes priority over everything, including mid-ITER. Sets state=IDLE, HI=0, LO=0, div_by_zero=0, count=0. stall, busy and hilo_out are 0 in the cycle after reset. ALUCon stays purely combinational.

Test Plan:
- Decode sweep, all ALUOp/funct combinations: and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100, lw 0010, beq 0110. funct 000111 -> 1111 with illegal_op=1. With valid=0, illegal_op=0.
- mult rs=7, rt=0xFFFFFFFD (-3) -> stall high exactly 34 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; mfhi/mflo return those values on hilo_out.
- multu 0xFFFFFFFF * 2 -> HI=0x00000001, LO=0xFFFFFFFE. div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 -> LO=14, HI=2.
- divu 0x1234/0 -> div_by_zero=1, HI=0x1234, LO=0xFFFFFFFF. A following mult clears the flag. div 0x80000000/-1 -> LO=0x80000000, HI=0.
- Assert reset in cycle T+10 of a mult -> next cycle stall=0, busy=0, HI=LO=0. A new mult issued right after completes normally in 34 cycles.
- Back-to-back mult then div with valid held high across the stall -> each executes exactly once, for 68 total stall cycles. A bubble (valid=0) with funct=mult does not start the sequencer.

Source files
------------

// File: rtl/alu_ctrl_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_muldiv_if
// Description : EX-stage bundle between the pipeline and the ALU control /
//               multiply-divide block.
//   master (pipeline) drives : valid, ALUOp, funct, rs_val, rt_val
//   slave  (block)    drives : ALUCon, illegal_op, stall, busy, hilo_out,
//                              div_by_zero
// Revision    : 1.0  initial release
// ============================================================================
interface alu_ctrl_muldiv_if #(
  parameter int WIDTH    = 32,
  parameter int ALUCON_W = 4
);
  logic                valid;
  logic [1:0]          ALUOp;
  logic [5:0]          funct;
  logic [WIDTH-1:0]    rs_val;
  logic [WIDTH-1:0]    rt_val;
  logic [ALUCON_W-1:0] ALUCon;
  logic                illegal_op;
  logic                stall;
  logic                busy;
  logic [WIDTH-1:0]    hilo_out;
  logic                div_by_zero;

  modport master (
    output valid, ALUOp, funct, rs_val, rt_val,
    input  ALUCon, illegal_op, stall, busy, hilo_out, div_by_zero
  );

  modport slave (
    input  valid, ALUOp, funct, rs_val, rt_val,
    output ALUCon, illegal_op, stall, busy, hilo_out, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_muldiv
// Description : MIPS EX-stage ALU control decode plus HI/LO register pair and
//               an iterative radix-2 sequencer for mult/multu/div/divu.
// Ports       :
//   clk    - pipeline clock, rising edge
//   reset  - synchronous, active-high
//   bus    - alu_ctrl_muldiv_if.slave:
//            in : valid, ALUOp[1:0], funct[5:0], rs_val, rt_val
//            out: ALUCon (comb), illegal_op (comb), stall, busy,
//                 hilo_out (mfhi/mflo read port), div_by_zero (sticky)
// Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_muldiv #(
  parameter int WIDTH    = 32,
  parameter int ALUCON_W = 4
) (
  input  wire                 clk,
  input  wire                 reset,
  alu_ctrl_muldiv_if.slave    bus
);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam int              CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;     // mult: {partial, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0]     opb_q;     // multiplicand or divisor magnitude
  logic                 is_div_q;
  logic                 neg_lo_q;  // negate product / quotient in FIX
  logic                 neg_hi_q;  // negate remainder in FIX (div only)
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 dbz_q;

  // ---------------------------------------------------------------- decode
  logic [3:0] w_alucon;
  logic       w_legal;
  logic       w_is_muldiv;
  logic       w_is_mfhi;
  logic       w_is_mflo;

  always_comb begin
    w_alucon    = 4'b1111;
    w_legal     = 1'b0;
    w_is_muldiv = 1'b0;
    w_is_mfhi   = 1'b0;
    w_is_mflo   = 1'b0;
    case (bus.ALUOp)
      2'b00: begin w_alucon = 4'b0010; w_legal = 1'b1; end
      2'b01: begin w_alucon = 4'b0110; w_legal = 1'b1; end
      2'b10: begin
        case (bus.funct)
          F_AND: begin w_alucon = 4'b0000; w_legal = 1'b1; end
          F_OR:  begin w_alucon = 4'b0001; w_legal = 1'b1; end
          F_ADD: begin w_alucon = 4'b0010; w_legal = 1'b1; end
          F_SUB: begin w_alucon = 4'b0110; w_legal = 1'b1; end
          F_SLT: begin w_alucon = 4'b0111; w_legal = 1'b1; end
          F_NOR: begin w_alucon = 4'b1100; w_legal = 1'b1; end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            w_alucon = 4'b0010; w_legal = 1'b1; w_is_muldiv = 1'b1;
          end
          F_MFHI: begin w_alucon = 4'b0010; w_legal = 1'b1; w_is_mfhi = 1'b1; end
          F_MFLO: begin w_alucon = 4'b0010; w_legal = 1'b1; w_is_mflo = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.ALUCon     = ALUCON_W'(w_alucon);
  assign bus.illegal_op = bus.valid & ~w_legal;

  // ------------------------------------------------------- issue operands
  // funct[0] marks the unsigned variants, funct[1] the divides.
  logic             w_start;
  logic             w_op_div;
  logic             w_op_signed;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic             w_dbz;

  assign w_start     = bus.valid & w_is_muldiv & (state_q == S_IDLE);
  assign w_op_div    = bus.funct[1];
  assign w_op_signed = ~bus.funct[0];
  assign w_rs_neg    = w_op_signed & bus.rs_val[WIDTH-1];
  assign w_rt_neg    = w_op_signed & bus.rt_val[WIDTH-1];
  assign w_rs_mag    = w_rs_neg ? -bus.rs_val : bus.rs_val;
  assign w_rt_mag    = w_rt_neg ? -bus.rt_val : bus.rt_val;
  assign w_dbz       = w_op_div & (bus.rt_val == '0);

  // ------------------------------------------------------- iteration step
  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] acc_mul_d;
  assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
  assign acc_mul_d = acc_q[0] ? {w_mul_sum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract when it fits. An explicit compare (rather than a borrow bit)
  // keeps the zero-divisor case well defined: every step "fits", so the
  // quotient fills with ones and the remainder ends up equal to the dividend.
  logic [WIDTH:0]     w_div_trial;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_fit;
  logic [2*WIDTH-1:0] acc_div_d;
  assign w_div_trial = acc_q[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_trial - {1'b0, opb_q};
  assign w_div_fit   = (w_div_trial >= {1'b0, opb_q});
  assign acc_div_d   = w_div_fit ? {w_div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                 : {acc_q[2*WIDTH-2:0], 1'b0};

  logic [2*WIDTH-1:0] w_acc_neg;
  assign w_acc_neg = -acc_q;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            // Divide by zero keeps the raw dividend so HI returns rs_val
            // unmodified, and suppresses sign correction.
            acc_q    <= {{WIDTH{1'b0}}, w_dbz ? bus.rs_val : w_rs_mag};
            opb_q    <= w_rt_mag;
            is_div_q <= w_op_div;
            neg_lo_q <= ~w_dbz & (w_rs_neg ^ w_rt_neg);
            neg_hi_q <= ~w_dbz & w_rs_neg;
            dbz_q    <= w_dbz;
            cnt_q    <= '0;
            state_q  <= S_ITER;
          end
        end
        S_ITER: begin
          acc_q <= is_div_q ? acc_div_d : acc_mul_d;
          if (cnt_q == CNT_MAX) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (is_div_q) begin
            lo_q <= neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_q <= neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            {hi_q, lo_q} <= neg_lo_q ? w_acc_neg : acc_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- outputs
  assign bus.stall       = w_start | (state_q == S_ITER) | (state_q == S_FIX);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.div_by_zero = dbz_q;
  assign bus.hilo_out    = (bus.valid & w_is_mfhi) ? hi_q :
                           (bus.valid & w_is_mflo) ? lo_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_muldiv
// Description : Self-checking bench for alu_ctrl_muldiv. Expected results come
//               from plain 64-bit arithmetic on the instruction semantics.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_muldiv;
  localparam int W = 32;
  localparam int LAT = W + 2;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_ctrl_muldiv_if #(.WIDTH(W), .ALUCON_W(4)) bus ();
  alu_ctrl_muldiv #(.WIDTH(W), .ALUCON_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid = v; bus.ALUOp = op; bus.funct = f; bus.rs_val = a; bus.rt_val = b;
  endtask

  // Decode reference straight from the instruction table.
  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output logic [3:0] con, output logic legal);
    con = 4'b1111; legal = 1'b0;
    if (op == 2'b00) begin con = 4'b0010; legal = 1'b1; end
    else if (op == 2'b01) begin con = 4'b0110; legal = 1'b1; end
    else if (op == 2'b10) begin
      legal = 1'b1;
      case (f)
        6'b100100: con = 4'b0000;
        6'b100101: con = 4'b0001;
        6'b100000: con = 4'b0010;
        6'b100010: con = 4'b0110;
        6'b101010: con = 4'b0111;
        6'b100111: con = 4'b1100;
        6'b011000, 6'b011001, 6'b011010, 6'b011011,
        6'b010000, 6'b010010: con = 4'b0010;
        default: begin con = 4'b1111; legal = 1'b0; end
      endcase
    end
  endfunction

  function automatic void ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dbz = 1'b0;
    hi = '0; lo = '0;
    if (f == F_MULT) begin
      p = sa * sb; hi = p[63:32]; lo = p[31:0];
    end else if (f == F_MULTU) begin
      p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a; lo = '1; dbz = 1'b1;
    end else if (f == F_DIV) begin
      q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0];
    end else begin
      hi = a % b; lo = a / b;
    end
  endfunction

  // Hold an instruction in EX for exactly LAT cycles (starting just after a
  // rising edge), counting stall and busy, then replace it with a bubble.
  task automatic hold_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int n_stall, output int n_busy);
    n_stall = 0; n_busy = 0;
    drive(1'b1, 2'b10, f, a, b);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (bus.stall) n_stall++;
      if (bus.busy) n_busy++;
      @(posedge clk); #1;
    end
    drive(1'b0, 2'b10, F_MULT, 32'h0, 32'h0);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    drive(1'b1, 2'b10, F_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    chk({tag, "_mfhi"}, 64'(bus.hilo_out), 64'(ehi));
    chk({tag, "_mfhi_stall"}, 64'(bus.stall), 64'(0));
    @(posedge clk); #1;
    drive(1'b1, 2'b10, F_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    chk({tag, "_mflo"}, 64'(bus.hilo_out), 64'(elo));
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
  endtask

  task automatic run_check(input string tag, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo;
    logic edbz;
    int ns, nb;
    ref_md(f, a, b, ehi, elo, edbz);
    hold_op(f, a, b, ns, nb);
    chk({tag, "_stallcyc"}, 64'(ns), 64'(LAT));
    chk({tag, "_busycyc"}, 64'(nb), 64'(LAT - 1));
    @(negedge clk);
    chk({tag, "_stall_after"}, 64'(bus.stall), 64'(0));
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
    @(posedge clk); #1;
    read_hilo(tag, ehi, elo);
  endtask

  initial begin
    logic [3:0]  econ;
    logic        elegal;
    logic [31:0] ehi, elo, ra, rb;
    logic        edbz;
    logic [5:0]  rf;
    int          ns, nb, total;

    // ------------------------------------------------ reset state
    reset = 1'b1;
    drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", 64'(bus.stall), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_dbz", 64'(bus.div_by_zero), 64'(0));
    chk("rst_hilo_bubble", 64'(bus.hilo_out), 64'(0));
    @(posedge clk); #1;
    read_hilo("rst", 32'h0, 32'h0);

    // ------------------------------------------------ decode sweep
    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 64; f++) begin
        ref_decode(op[1:0], f[5:0], econ, elegal);
        drive(1'b0, op[1:0], f[5:0], 32'h0, 32'h0);
        #1;
        chk($sformatf("dec_alucon_op%0d_f%02h", op, f), 64'(bus.ALUCon), 64'(econ));
        chk($sformatf("dec_illegal_v0_op%0d_f%02h", op, f), 64'(bus.illegal_op), 64'(0));
        // Valid mult/div would launch the sequencer; those are exercised below.
        if (!(op == 2 && f >= 24 && f <= 27)) begin
          drive(1'b1, op[1:0], f[5:0], 32'h0, 32'h0);
          #1;
          chk($sformatf("dec_illegal_v1_op%0d_f%02h", op, f), 64'(bus.illegal_op), 64'(!elegal));
        end
      end
    end
    drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // ------------------------------------------------ directed ops
    run_check("mult_7_m3", F_MULT, 32'd7, 32'hFFFF_FFFD);
    chk("mult_7_m3_hi_const", 64'(dut.hi_q), 64'(32'hFFFF_FFFF));
    run_check("multu_max_2", F_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_check("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2);
    run_check("divu_100_7", F_DIVU, 32'd100, 32'd7);
    run_check("divu_by0", F_DIVU, 32'h0000_1234, 32'd0);
    run_check("mult_clears_dbz", F_MULT, 32'd3, 32'd5);
    run_check("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("mult_min_min", F_MULT, 32'h8000_0000, 32'h8000_0000);
    run_check("div_by0_signed", F_DIV, 32'hFFFF_FF00, 32'd0);

    // Reset while idle clears the sticky flag and HI/LO.
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_idle_dbz", 64'(bus.div_by_zero), 64'(0));
    @(posedge clk); #1;
    read_hilo("rst_idle", 32'h0, 32'h0);

    // ------------------------------------------------ reset mid-ITER
    run_check("pre_rst_mult", F_MULT, 32'd1234, 32'd5678);
    drive(1'b1, 2'b10, F_MULT, 32'd5, 32'd9);
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    drive(1'b0, 2'b00, 6'h0, 32'h0, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall", 64'(bus.stall), 64'(0));
    chk("rst_mid_busy", 64'(bus.busy), 64'(0));
    @(posedge clk); #1;
    read_hilo("rst_mid", 32'h0, 32'h0);
    run_check("post_rst_mult", F_MULT, 32'hFFFF_FFF0, 32'd3);

    // ------------------------------------------------ back-to-back mult/div
    ref_md(F_DIV, 32'd1000, 32'hFFFF_FFF9, ehi, elo, edbz);
    hold_op(F_MULT, 32'd11, 32'd13, ns, nb);
    total = ns;
    hold_op(F_DIV, 32'd1000, 32'hFFFF_FFF9, ns, nb);
    total += ns;
    // hold_op leaves a bubble carrying the mult funct: it must not start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.stall) total++;
      chk($sformatf("b2b_bubble_busy%0d", i), 64'(bus.busy), 64'(0));
      @(posedge clk); #1;
    end
    chk("b2b_total_stall", 64'(total), 64'(2 * LAT));
    read_hilo("b2b_div", ehi, elo);

    // ------------------------------------------------ randomized ops
    for (int k = 0; k < 12; k++) begin
      rf = {4'b0110, 2'($urandom_range(0, 3))};
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_check($sformatf("rand%0d_f%02h", k, rf), rf, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
